// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed data memory for the RV32I load/store path.
// Supports LB/LH/LW/LBU/LHU and SB/SH/SW through a REQ/DONE handshake with
// WAIT_STATES extra cycles. Range and FUNCT3 errors are reported on ERR.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned half/word accesses also
// raise ERR and are suppressed.
`timescale 1ns/1ps
module dmem_lsu #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       WDATA,
  output logic              READY,
  output logic              DONE,
  output logic [31:0]       RDATA,
  output logic              ERR
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              acc_we;
  logic [2:0]        acc_funct3;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              commit;
  logic              bad_range;
  logic              bad_funct3;
  logic              misaligned;
  logic              req_err;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       cur_word;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_word;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       store_word;

  // Active request: live inputs on the accept cycle (zero-wait commit), latched copy afterwards
  always_comb begin
    if (state == IDLE) begin
      acc_we     = WE;
      acc_funct3 = FUNCT3;
      acc_addr   = ADDR;
      acc_wdata  = WDATA;
    end else begin
      acc_we     = we_q;
      acc_funct3 = funct3_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
    if (WAIT_STATES == 0) commit = (state == IDLE) && REQ;
    else                  commit = (state == WAIT) && (wait_cnt == 4'd0);
  end

  // Error classification of the active request
  always_comb begin
    bad_range = (acc_addr >= MEM_BYTES);
    if (acc_we) bad_funct3 = !(acc_funct3 inside {3'b000, 3'b001, 3'b010});
    else        bad_funct3 =  (acc_funct3 inside {3'b011, 3'b110, 3'b111});
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned = ((acc_funct3[1:0] == 2'b01) && acc_addr[0]) ||
                 ((acc_funct3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    req_err = bad_range | bad_funct3 | misaligned;
  end

  // Load extraction and store byte merging on the addressed word
  always_comb begin
    word_idx = acc_addr[IDX_W+1:2];
    cur_word = mem[word_idx];
    case (acc_addr[1:0])
      2'd0:    sel_byte = cur_word[7:0];
      2'd1:    sel_byte = cur_word[15:8];
      2'd2:    sel_byte = cur_word[23:16];
      default: sel_byte = cur_word[31:24];
    endcase
    sel_half = acc_addr[1] ? cur_word[31:16] : cur_word[15:0];
    case (acc_funct3)
      3'b000:  load_word = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_word = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_word = cur_word;
      3'b100:  load_word = {24'b0, sel_byte};
      3'b101:  load_word = {16'b0, sel_half};
      default: load_word = 32'b0;
    endcase
    case (acc_funct3)
      3'b000: begin
        byte_en   = 4'b0001 << acc_addr[1:0];
        wdata_rep = {4{acc_wdata[7:0]}};
      end
      3'b001: begin
        byte_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{acc_wdata[15:0]}};
      end
      3'b010: begin
        byte_en   = 4'b1111;
        wdata_rep = acc_wdata;
      end
      default: begin
        byte_en   = 4'b0000;
        wdata_rep = acc_wdata;
      end
    endcase
    store_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) store_word[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

  // Handshake FSM with registered READY/DONE/RDATA/ERR
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      READY    <= 1'b1;
      DONE     <= 1'b0;
      RDATA    <= 32'b0;
      ERR      <= 1'b0;
    end else begin
      DONE  <= 1'b0;
      RDATA <= 32'b0;
      ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            we_q     <= WE;
            funct3_q <= FUNCT3;
            addr_q   <= ADDR;
            wdata_q  <= WDATA;
            wait_cnt <= WAIT_LOAD;
            READY    <= 1'b0;
            state    <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else                  state    <= RESP;
        end
        RESP: begin
          state <= IDLE;
          READY <= 1'b1;
        end
        default: begin
          state <= IDLE;
          READY <= 1'b1;
        end
      endcase
      if (commit) begin
        DONE  <= 1'b1;
        ERR   <= req_err;
        RDATA <= (!acc_we && !req_err) ? load_word : 32'b0;
      end
    end
  end

  // Memory array: cleared on reset, written only by an error-free store at commit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'b0;
    end else if (commit && acc_we && !req_err) begin
      mem[word_idx] <= store_word;
    end
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised, byte-addressed data memory for the single-cycle RISC-V core's load/store path, sitting behind the ALU address output. It replaces the word-only memory with RV32I access sizes: LB/LH/LW/LBU/LHU and SB/SH/SW. Accesses use a request/done handshake with configurable wait states. Range and alignment errors are reported to the core instead of corrupting memory.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; power of two, at least 4.
- ADDR_W, 32: byte-address width.
- WAIT_STATES, 0: extra cycles between accept and completion, 0..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ  in  1  access request; sampled only while READY=1.
- WE  in  1  1 = store, 0 = load; qualified by REQ.
- FUNCT3  in  3  RISC-V funct3 access size/sign.
- ADDR  in  ADDR_W  byte address.
- WDATA  in  32  store data; the low byte/half/word is used.
- READY  out  1  block can accept a request this cycle.
- DONE  out  1  one-cycle completion pulse for every accepted request.
- RDATA  out  32  load result, valid when DONE=1 for a load; otherwise 0.
- ERR  out  1  valid with DONE; the request was rejected with no side effect.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: READY=1. If REQ=1, latch WE, FUNCT3, ADDR and WDATA. Go to WAIT if WAIT_STATES>0, otherwise to RESP.
  - WAIT: a down-counter loads WAIT_STATES-1 at accept and decrements each cycle. At 0, go to RESP.
  - RESP: DONE=1 for exactly one cycle, then return to IDLE. READY=0 in WAIT and RESP.
- Commit point is the edge entering RESP. At that edge:
  - a store writes its bytes into memory;
  - a load registers RDATA from memory contents *before* that edge.
- Word index: ADDR[log2(DEPTH_WORDS)+1:2]. Byte lane: ADDR[1:0]. Little-endian.
- Store byte enables:
  - SB (000): one lane, ADDR[1:0].
  - SH (001): lanes {ADDR[1],0} and {ADDR[1],1}.
  - SW (010): all four lanes.
  - Unselected bytes are unchanged.
- Load extraction:
  - LB (000): sign-extend byte.
  - LH (001): sign-extend half.
  - LW (010): full word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend half.
- ERR conditions (memory unchanged, RDATA=0, DONE still pulses):
  - ADDR >= 4*DEPTH_WORDS (out of range);
  - load FUNCT3 in {011, 110, 111};
  - store FUNCT3 not in {000, 001, 010};
  - misaligned access when DMEM_ALIGN_CHECK_EN is defined.
- Out-of-range and illegal-FUNCT3 checks are evaluated on the latched request.

## Timing
- Reset values:
  - state = IDLE, READY=1, DONE=0, RDATA=0, ERR=0;
  - wait counter = 0;
  - all memory words = 0, cleared asynchronously.
- Latency: accept at edge N, then DONE high during cycle N+1+WAIT_STATES.
- Throughput: one request every 2+WAIT_STATES cycles.
- Ordering: a load accepted after a store's DONE cycle sees the stored data.
- REQ in WAIT or RESP is ignored. Requests are not queued, and the requester must hold them until READY=1.
- Reset mid-operation (WAIT or RESP) aborts the request:
  - a pending store is not written;
  - DONE does not pulse;
  - the next cycle after RST deasserts is IDLE with READY=1.
- RDATA and ERR hold their values only during the DONE cycle, then return to 0.

## Configuration
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: misaligned access raises ERR and is suppressed (no write, RDATA=0).
  - halfword with ADDR[0]=1;
  - word with ADDR[1:0]!=0.
- Undefined: no alignment check.
  - halfword ignores ADDR[0];
  - word ignores ADDR[1:0].
  - ERR then covers only range and FUNCT3 errors.

## Test plan
- Reset, then LW at 0x0 with WAIT_STATES=0 -> DONE at cycle 2, RDATA=0x00000000, ERR=0.
- SW 0x8000_80F0 at 0x10; then LB at 0x10 -> 0xFFFF_FFF0, LBU at 0x10 -> 0x0000_00F0, LH at 0x12 -> 0xFFFF_8000, LHU at 0x12 -> 0x0000_8000.
- SB 0xAB at 0x21 over word 0x1122_3344 -> LW at 0x20 returns 0x1122_AB44. SH 0xBEEF at 0x22 -> LW returns 0xBEEF_AB44.
- With WAIT_STATES=3:
  - REQ held high through WAIT -> exactly one DONE, 4 cycles after accept;
  - a second REQ during WAIT is ignored.
- SW to 0x100 (DEPTH_WORDS=64) -> ERR=1 with DONE, and all memory words are unchanged. Load with FUNCT3=011 -> ERR=1, RDATA=0.
- Misaligned LW at 0x13:
  - macro defined -> ERR=1;
  - macro undefined -> returns the word at 0x10, ERR=0.
- Assert RST while in WAIT during an SW -> no DONE, target word still 0, READY=1 after release.
